fpu_ss_writeback: RTL and testbench
===================================

FPU_SS_WRITEBACK -- requirements
Module: fpu_ss_writeback

Interface
REQ-001 SHALL have parameter RES_DEPTH, default 2, meaning result-FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports fpu_valid_i in 1, fpu_ready_o out 1: FPU result handshake.
REQ-005 SHALL have ports fpu_result_i in 32 (result data), fpu_tag_i in fpu_tag_t (addr, rd_is_fp, id), fpu_status_i in 5 (NV,DZ,OF,UF,NX).
REQ-006 SHALL have ports lsu_valid_i in 1, lsu_ready_o out 1, lsu_meta_i in mem_metadata_t, lsu_rdata_i in 32: FP-load writeback.
REQ-007 SHALL have ports fpr_we_o out 1, fpr_waddr_o out 5, fpr_wdata_o out 32: FP regfile write port.
REQ-008 SHALL have ports x_result_valid_o out 1, x_result_ready_i in 1, x_result_o out x_result_t: cv-x-if result channel.
REQ-009 SHALL have ports fflags_o out 5 (sticky flags) and fflags_clr_i in 1 (clear strobe).

Function
REQ-010 Acceptance: LSU accepted when lsu_valid_i & lsu_ready_o; FPU accepted when fpu_valid_i & fpu_ready_o; at most one acceptance per cycle.
REQ-011 lsu_ready_o SHALL equal FIFO-not-full; fpu_ready_o SHALL equal FIFO-not-full & !lsu_valid_i (LSU has fixed priority).
REQ-012 A full FIFO SHALL deassert both readies even if x_result_ready_i is high that cycle (no push-while-full).
REQ-013 FP write: accepted LSU entry with lsu_meta_i.we=1, or accepted FPU entry with rd_is_fp=1, SHALL pulse fpr_we_o exactly one cycle later with registered addr/data (LSU: lsu_meta_i.rd/lsu_rdata_i; FPU: tag.addr/fpu_result_i).
REQ-014 fpr_we_o SHALL be 0 in all other cycles; fpr_waddr_o/fpr_wdata_o hold last value when idle.
REQ-015 Every acceptance SHALL push one x_result_t entry: id from source id; rd = dest addr; exc=0; exccode=0.
REQ-016 Integer-destination FPU result (rd_is_fp=0): we=1, data=fpu_result_i, ecswe=3'b000, ecsdata=0.
REQ-017 FP-destination entries (either source): we=0, data=0, ecswe=3'b010, ecsdata=6'b001100 (FS dirty).
REQ-018 LSU entry with lsu_meta_i.we=0 (store): we=0, data=0, ecswe=0, ecsdata=0, no FP write.
REQ-019 FIFO: x_result_valid_o = !empty; x_result_o = head entry, stable while valid & !ready; pop on valid & ready.
REQ-020 Latency: entry pushed in cycle N SHALL be visible on x_result_o in N+1 when FIFO empty at N.
REQ-021 Simultaneous push and pop with FIFO not full SHALL keep occupancy constant and order FIFO-preserving; pointers wrap modulo RES_DEPTH.
REQ-022 fflags_o: on FPU acceptance fflags <= fflags | fpu_status_i; on fflags_clr_i fflags <= 0; both same cycle -> fflags <= fpu_status_i.
REQ-023 LSU acceptances SHALL NOT modify fflags_o.

Reset
REQ-024 rst_i high at a rising edge SHALL empty the FIFO, zero fflags_o, fpr_we_o, fpr_waddr_o, fpr_wdata_o and x_result_o; x_result_valid_o=0.
REQ-025 Reset mid-operation SHALL discard all queued entries and any pending FP write; readies valid-based from the cycle after reset deasserts.

Structure
REQ-026 Constants ECS_FS_DIRTY (6'b001100) and ECSWE_FS (3'b010) SHALL be added to fpu_ss_pkg; x_result_t, fpu_tag_t, mem_metadata_t reused from it.
REQ-027 FIFO SHALL be a sub-module fpu_ss_result_fifo (parameterised type and depth, push/pop/full/empty).

Verification
REQ-028 FPU int result id=3, addr=10, data=0xDEADBEEF, rd_is_fp=0, ready=1 -> next cycle x_result valid, we=1, rd=10, data=0xDEADBEEF, no fpr_we_o.
REQ-029 lsu_valid_i and fpu_valid_i same cycle (FP dests f1, f2) -> fpu_ready_o=0; f1 written at N+1, f2 at N+2; results ordered LSU then FPU, both ecswe=3'b010.
REQ-030 x_result_ready_i=0, push 2 entries (RES_DEPTH=2) -> both readies low; raise ready -> entries popped in order, readies rise after first pop.
REQ-031 FPU statuses 5'b00001 then 5'b10000 -> fflags_o=5'b10001; clr with status 5'b00100 same cycle -> 5'b00100.
REQ-032 Assert rst_i with 2 queued entries -> next cycle x_result_valid_o=0, fflags_o=0, fpr_we_o=0.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem writeback path.
package fpu_ss_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  localparam logic [5:0] ECS_FS_DIRTY = 6'b001100;
  localparam logic [2:0] ECSWE_FS     = 3'b010;

  typedef struct packed {
    logic [4:0]            addr;
    logic                  rd_is_fp;
    logic [X_ID_WIDTH-1:0] id;
  } fpu_tag_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
  } mem_metadata_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic [2:0]            ecswe;
    logic [5:0]            ecsdata;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

endpackage

// File: rtl/fpu_ss_result_fifo.sv
// Small synchronous FIFO with registered storage; head is visible the cycle after a push.
module fpu_ss_result_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T               r_mem [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push, w_pop;

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpu_ss_writeback.sv
// Merges FPU results and FP loads into the FP regfile and the cv-x-if result channel.
module fpu_ss_writeback
  import fpu_ss_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fpu_valid_i,
  output logic          fpu_ready_o,
  input  logic [31:0]   fpu_result_i,
  input  fpu_tag_t      fpu_tag_i,
  input  logic [4:0]    fpu_status_i,
  input  logic          lsu_valid_i,
  output logic          lsu_ready_o,
  input  mem_metadata_t lsu_meta_i,
  input  logic [31:0]   lsu_rdata_i,
  output logic          fpr_we_o,
  output logic [4:0]    fpr_waddr_o,
  output logic [31:0]   fpr_wdata_o,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o,
  output logic [4:0]    fflags_o,
  input  logic          fflags_clr_i
);

  logic        w_full, w_empty;
  logic        w_lsu_acc, w_fpu_acc;
  logic        w_fp_we;
  logic [4:0]  w_fp_addr;
  logic [31:0] w_fp_data;
  x_result_t   w_entry;

  logic        r_fpr_we;
  logic [4:0]  r_fpr_waddr;
  logic [31:0] r_fpr_wdata;
  logic [4:0]  r_fflags;

  // LSU has fixed priority; the FPU is stalled whenever a load is presented.
  assign lsu_ready_o = ~w_full;
  assign fpu_ready_o = ~w_full & ~lsu_valid_i;
  assign w_lsu_acc   = lsu_valid_i & lsu_ready_o;
  assign w_fpu_acc   = fpu_valid_i & fpu_ready_o;

  assign w_fp_we   = (w_lsu_acc & lsu_meta_i.we) | (w_fpu_acc & fpu_tag_i.rd_is_fp);
  assign w_fp_addr = w_lsu_acc ? lsu_meta_i.rd : fpu_tag_i.addr;
  assign w_fp_data = w_lsu_acc ? lsu_rdata_i : fpu_result_i;

  always_comb begin
    w_entry = '0;
    if (w_lsu_acc) begin
      w_entry.id = lsu_meta_i.id;
      w_entry.rd = lsu_meta_i.rd;
      if (lsu_meta_i.we) begin
        w_entry.ecswe   = ECSWE_FS;
        w_entry.ecsdata = ECS_FS_DIRTY;
      end
    end else if (w_fpu_acc) begin
      w_entry.id = fpu_tag_i.id;
      w_entry.rd = fpu_tag_i.addr;
      if (fpu_tag_i.rd_is_fp) begin
        w_entry.ecswe   = ECSWE_FS;
        w_entry.ecsdata = ECS_FS_DIRTY;
      end else begin
        w_entry.we   = 1'b1;
        w_entry.data = fpu_result_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fpr_we    <= 1'b0;
      r_fpr_waddr <= '0;
      r_fpr_wdata <= '0;
      r_fflags    <= '0;
    end else begin
      r_fpr_we <= w_fp_we;
      if (w_fp_we) begin
        r_fpr_waddr <= w_fp_addr;
        r_fpr_wdata <= w_fp_data;
      end
      // A clear coinciding with an FPU result keeps only the new status.
      if (fflags_clr_i)   r_fflags <= w_fpu_acc ? fpu_status_i : 5'b0;
      else if (w_fpu_acc) r_fflags <= r_fflags | fpu_status_i;
    end
  end

  assign fpr_we_o         = r_fpr_we;
  assign fpr_waddr_o      = r_fpr_waddr;
  assign fpr_wdata_o      = r_fpr_wdata;
  assign fflags_o         = r_fflags;
  assign x_result_valid_o = ~w_empty;

  fpu_ss_result_fifo #(
    .T     (x_result_t),
    .Depth (RES_DEPTH)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_lsu_acc | w_fpu_acc),
    .data_i  (w_entry),
    .pop_i   (x_result_ready_i),
    .data_o  (x_result_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

// File: tb/tb_fpu_ss_writeback.sv
// Self-checking bench: vector table plus directed sequences, result scoreboard queue.
module tb_fpu_ss_writeback;
  import fpu_ss_pkg::*;

  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          fpu_valid_i = 1'b0;
  logic          fpu_ready_o;
  logic [31:0]   fpu_result_i = '0;
  fpu_tag_t      fpu_tag_i = '0;
  logic [4:0]    fpu_status_i = '0;
  logic          lsu_valid_i = 1'b0;
  logic          lsu_ready_o;
  mem_metadata_t lsu_meta_i = '0;
  logic [31:0]   lsu_rdata_i = '0;
  logic          fpr_we_o;
  logic [4:0]    fpr_waddr_o;
  logic [31:0]   fpr_wdata_o;
  logic          x_result_valid_o;
  logic          x_result_ready_i = 1'b1;
  x_result_t     x_result_o;
  logic [4:0]    fflags_o;
  logic          fflags_clr_i = 1'b0;

  int        total = 0;
  int        bad = 0;
  x_result_t sb[$];
  logic [4:0] m_ff = '0;

  always #5 clk = ~clk;

  fpu_ss_writeback #(.RES_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .fpu_valid_i      (fpu_valid_i),
    .fpu_ready_o      (fpu_ready_o),
    .fpu_result_i     (fpu_result_i),
    .fpu_tag_i        (fpu_tag_i),
    .fpu_status_i     (fpu_status_i),
    .lsu_valid_i      (lsu_valid_i),
    .lsu_ready_o      (lsu_ready_o),
    .lsu_meta_i       (lsu_meta_i),
    .lsu_rdata_i      (lsu_rdata_i),
    .fpr_we_o         (fpr_we_o),
    .fpr_waddr_o      (fpr_waddr_o),
    .fpr_wdata_o      (fpr_wdata_o),
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_o       (x_result_o),
    .fflags_o         (fflags_o),
    .fflags_clr_i     (fflags_clr_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic x_result_t mk(input logic [3:0] id, input logic [31:0] d,
                                   input logic [4:0] rd, input logic we,
                                   input logic [2:0] ecswe, input logic [5:0] ecs);
    x_result_t r;
    r = '0;
    r.id = id; r.data = d; r.rd = rd; r.we = we; r.ecswe = ecswe; r.ecsdata = ecs;
    return r;
  endfunction

  // Head of the result channel is checked against the scoreboard every cycle.
  always @(negedge clk) begin
    if (!rst_i) begin
      chk("x_valid", 64'(x_result_valid_o), 64'(sb.size() != 0));
      if (x_result_valid_o && sb.size() != 0) begin
        chk("x_result", 64'(x_result_o), 64'(sb[0]));
        if (x_result_ready_i) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input logic lv, input mem_metadata_t lm, input logic [31:0] ld,
                       input logic fv, input fpu_tag_t ft, input logic [31:0] fr,
                       input logic [4:0] fs, input logic clr,
                       input x_result_t el, input x_result_t ef);
    logic       e_lr, e_fr, acc_l, acc_f, ewe;
    logic [4:0] ea;
    logic [31:0] ed;
    lsu_valid_i = lv; lsu_meta_i = lm; lsu_rdata_i = ld;
    fpu_valid_i = fv; fpu_tag_i = ft; fpu_result_i = fr; fpu_status_i = fs;
    fflags_clr_i = clr;
    #1;
    e_lr = sb.size() < DEPTH;
    e_fr = e_lr & ~lv;
    chk("lsu_ready", 64'(lsu_ready_o), 64'(e_lr));
    chk("fpu_ready", 64'(fpu_ready_o), 64'(e_fr));
    acc_l = lv & e_lr;
    acc_f = fv & e_fr;
    ewe = (acc_l & lm.we) | (acc_f & ft.rd_is_fp);
    ea  = acc_l ? lm.rd : ft.addr;
    ed  = acc_l ? ld : fr;
    if (clr) m_ff = acc_f ? fs : 5'b0;
    else if (acc_f) m_ff = m_ff | fs;
    @(posedge clk);
    #1;
    if (acc_l) sb.push_back(el);
    if (acc_f) sb.push_back(ef);
    chk("fpr_we", 64'(fpr_we_o), 64'(ewe));
    if (ewe) begin
      chk("fpr_waddr", 64'(fpr_waddr_o), 64'(ea));
      chk("fpr_wdata", 64'(fpr_wdata_o), 64'(ed));
    end
    chk("fflags", 64'(fflags_o), 64'(m_ff));
    lsu_valid_i = 1'b0; fpu_valid_i = 1'b0; fflags_clr_i = 1'b0; fpu_status_i = '0;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic        is_lsu;
    logic        fp;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  st;
    x_result_t   exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'd3,  5'd10, 32'hDEADBEEF, 5'b00000,
                mk(4'd3, 32'hDEADBEEF, 5'd10, 1'b1, 3'b000, 6'b000000)};
    vecs[1] = '{1'b0, 1'b1, 4'd1,  5'd5,  32'h3F800000, 5'b00001,
                mk(4'd1, 32'h0, 5'd5, 1'b0, 3'b010, 6'b001100)};
    vecs[2] = '{1'b1, 1'b1, 4'd2,  5'd7,  32'h12345678, 5'b00000,
                mk(4'd2, 32'h0, 5'd7, 1'b0, 3'b010, 6'b001100)};
    vecs[3] = '{1'b1, 1'b0, 4'd4,  5'd9,  32'hCAFEF00D, 5'b00000,
                mk(4'd4, 32'h0, 5'd9, 1'b0, 3'b000, 6'b000000)};
    vecs[4] = '{1'b0, 1'b0, 4'd15, 5'd31, 32'hFFFFFFFF, 5'b10000,
                mk(4'd15, 32'hFFFFFFFF, 5'd31, 1'b1, 3'b000, 6'b000000)};
    vecs[5] = '{1'b0, 1'b1, 4'd0,  5'd0,  32'h00000000, 5'b00010,
                mk(4'd0, 32'h0, 5'd0, 1'b0, 3'b010, 6'b001100)};

    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_x_valid", 64'(x_result_valid_o), 64'd0);
    chk("rst_x_result", 64'(x_result_o), 64'd0);
    chk("rst_fflags", 64'(fflags_o), 64'd0);
    chk("rst_fpr_we", 64'(fpr_we_o), 64'd0);
    chk("rst_fpr_waddr", 64'(fpr_waddr_o), 64'd0);
    chk("rst_fpr_wdata", 64'(fpr_wdata_o), 64'd0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_lsu)
        drive(1'b1, mem_metadata_t'{id: vecs[i].id, rd: vecs[i].rd, we: vecs[i].fp},
              vecs[i].data, 1'b0, '0, '0, '0, 1'b0, vecs[i].exp, '0);
      else
        drive(1'b0, '0, '0, 1'b1,
              fpu_tag_t'{addr: vecs[i].rd, rd_is_fp: vecs[i].fp, id: vecs[i].id},
              vecs[i].data, vecs[i].st, 1'b0, '0, vecs[i].exp);
    end
    chk("fflags_accum", 64'(fflags_o), 64'(5'b10011));

    // Same-cycle LSU and FPU: LSU first, FPU retried next cycle.
    drive(1'b1, mem_metadata_t'{id: 4'd5, rd: 5'd1, we: 1'b1}, 32'hAAAA0001,
          1'b1, fpu_tag_t'{addr: 5'd2, rd_is_fp: 1'b1, id: 4'd6}, 32'hBBBB0002, '0, 1'b0,
          mk(4'd5, 32'h0, 5'd1, 1'b0, 3'b010, 6'b001100),
          mk(4'd6, 32'h0, 5'd2, 1'b0, 3'b010, 6'b001100));
    chk("collide_f1", 64'(fpr_waddr_o), 64'd1);
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd2, rd_is_fp: 1'b1, id: 4'd6},
          32'hBBBB0002, '0, 1'b0, '0, mk(4'd6, 32'h0, 5'd2, 1'b0, 3'b010, 6'b001100));
    chk("collide_f2", 64'(fpr_waddr_o), 64'd2);
    idle();

    // Backpressure: fill the FIFO, then release.
    x_result_ready_i = 1'b0;
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd11, rd_is_fp: 1'b0, id: 4'd7}, 32'h00000011,
          '0, 1'b0, '0, mk(4'd7, 32'h11, 5'd11, 1'b1, 3'b000, 6'b0));
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd12, rd_is_fp: 1'b0, id: 4'd8}, 32'h00000012,
          '0, 1'b0, '0, mk(4'd8, 32'h12, 5'd12, 1'b1, 3'b000, 6'b0));
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd13, rd_is_fp: 1'b0, id: 4'd9}, 32'h00000013,
          '0, 1'b0, '0, mk(4'd9, 32'h13, 5'd13, 1'b1, 3'b000, 6'b0));
    drive(1'b1, mem_metadata_t'{id: 4'd9, rd: 5'd3, we: 1'b1}, 32'h5, 1'b0, '0, '0, '0, 1'b0,
          mk(4'd9, 32'h0, 5'd3, 1'b0, 3'b010, 6'b001100), '0);
    chk("full_lsu_ready", 64'(lsu_ready_o), 64'd0);
    x_result_ready_i = 1'b1;
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd14, rd_is_fp: 1'b0, id: 4'd10}, 32'h14,
          '0, 1'b0, '0, mk(4'd10, 32'h14, 5'd14, 1'b1, 3'b000, 6'b0));
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd14, rd_is_fp: 1'b0, id: 4'd10}, 32'h14,
          '0, 1'b0, '0, mk(4'd10, 32'h14, 5'd14, 1'b1, 3'b000, 6'b0));
    repeat (3) idle();

    // Sticky flags and clear/accrue collision; LSU leaves flags alone.
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, '0, '0);
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd4, rd_is_fp: 1'b0, id: 4'd1}, 32'h1,
          5'b00001, 1'b0, '0, mk(4'd1, 32'h1, 5'd4, 1'b1, 3'b000, 6'b0));
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd4, rd_is_fp: 1'b0, id: 4'd2}, 32'h2,
          5'b10000, 1'b0, '0, mk(4'd2, 32'h2, 5'd4, 1'b1, 3'b000, 6'b0));
    chk("fflags_or", 64'(fflags_o), 64'(5'b10001));
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd4, rd_is_fp: 1'b0, id: 4'd3}, 32'h3,
          5'b00100, 1'b1, '0, mk(4'd3, 32'h3, 5'd4, 1'b1, 3'b000, 6'b0));
    chk("fflags_clr_set", 64'(fflags_o), 64'(5'b00100));
    drive(1'b1, mem_metadata_t'{id: 4'd4, rd: 5'd6, we: 1'b1}, 32'h6, 1'b0, '0, '0, 5'b11111,
          1'b0, mk(4'd4, 32'h0, 5'd6, 1'b0, 3'b010, 6'b001100), '0);
    chk("fflags_lsu", 64'(fflags_o), 64'(5'b00100));
    repeat (2) idle();

    // Reset with queued entries and a concurrent FP write.
    x_result_ready_i = 1'b0;
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd20, rd_is_fp: 1'b0, id: 4'd5}, 32'h20,
          5'b01000, 1'b0, '0, mk(4'd5, 32'h20, 5'd20, 1'b1, 3'b000, 6'b0));
    drive(1'b0, '0, '0, 1'b1, fpu_tag_t'{addr: 5'd21, rd_is_fp: 1'b0, id: 4'd6}, 32'h21,
          5'b00010, 1'b0, '0, mk(4'd6, 32'h21, 5'd21, 1'b1, 3'b000, 6'b0));
    rst_i = 1'b1;
    fpu_valid_i = 1'b1;
    fpu_tag_i = fpu_tag_t'{addr: 5'd22, rd_is_fp: 1'b1, id: 4'd7};
    fpu_result_i = 32'h22;
    fpu_status_i = 5'b00001;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    fpu_valid_i = 1'b0;
    fpu_status_i = '0;
    sb.delete();
    m_ff = '0;
    chk("rstq_x_valid", 64'(x_result_valid_o), 64'd0);
    chk("rstq_fflags", 64'(fflags_o), 64'd0);
    chk("rstq_fpr_we", 64'(fpr_we_o), 64'd0);
    chk("rstq_x_result", 64'(x_result_o), 64'd0);
    x_result_ready_i = 1'b1;
    idle();
    drive(1'b1, mem_metadata_t'{id: 4'd1, rd: 5'd8, we: 1'b0}, 32'h8, 1'b0, '0, '0, '0, 1'b0,
          mk(4'd1, 32'h0, 5'd8, 1'b0, 3'b000, 6'b0), '0);
    repeat (3) idle();
    chk("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
